// File: rtl/dp_adder_job_ctrl_pkg.sv
// dp_adder_job_ctrl_pkg: shared state encoding and counter width for the adder job controller
package dp_adder_job_ctrl_pkg;
  localparam int DP_CTRL_CNT_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} dp_ctrl_state_e;
endpackage

// File: rtl/dp_adder_job_ctrl_beat_counter.sv
// dp_beat_counter: saturating beat counter that clears on job accept and stops at the job length
module dp_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         reached
);
  assign reached = cnt >= limit;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !reached) cnt <= cnt + W'(1);
endmodule

// File: rtl/dp_adder_job_ctrl.sv
// dp_adder_job_ctrl: job sequencer for the dual-lane result adder
// Optional sticky protocol checker enabled by defining DP_ADDER_CTRL_ERR_EN.
module dp_adder_job_ctrl
  import dp_adder_job_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = DP_CTRL_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic                 job_add_i,
  input  logic [CNT_WIDTH-1:0] job_len_i,
  input  logic                 dp0_hs_i,
  input  logic                 dp1_hs_i,
  input  logic                 out0_hs_i,
  input  logic                 out1_hs_i,
  output logic                 add_enable_o,
  output logic                 gate0_o,
  output logic                 gate1_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] out_cnt_o,
  output logic                 err_o
);
  dp_ctrl_state_e state, nxt;
  logic [CNT_WIDTH-1:0] len, c0, c1, o0, o1;
  logic r0, r1, q0, q1, accept, run, cnt_en, in_done, out_done, unused_ok;
  assign unused_ok = test_mode_i;
  assign accept    = job_valid_i & job_ready_o;
  assign run       = state == RUN;
  assign cnt_en    = run | (state == DRAIN);
  assign in_done   = r0 & (add_enable_o | r1);
  assign out_done  = q1 & (add_enable_o | q0);
  assign out_cnt_o = add_enable_o ? o1 : o0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      add_enable_o <= 1'b0;
      len          <= '0;
    end else if (accept) begin
      add_enable_o <= job_add_i;
      len          <= job_len_i;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (job_len_i == '0) ? DONE : SETUP;
      SETUP:   nxt = RUN;
      RUN:     if (in_done) nxt = out_done ? DONE : DRAIN;
      DRAIN:   if (out_done) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    job_ready_o = state == IDLE;
    busy_o      = state != IDLE;
    done_o      = state == DONE;
    gate0_o     = run & !r0;
    gate1_o     = run & (add_enable_o ? !r0 : !r1);
  end
  // in add mode counter c0 tracks pairs and c1 stays idle
  dp_beat_counter #(.W(CNT_WIDTH)) u_c0 (.clk(clk_i), .rst(rst_i), .clr(accept),
    .inc(run & dp0_hs_i & (dp1_hs_i | !add_enable_o)), .limit(len), .cnt(c0), .reached(r0));
  dp_beat_counter #(.W(CNT_WIDTH)) u_c1 (.clk(clk_i), .rst(rst_i), .clr(accept),
    .inc(run & !add_enable_o & dp1_hs_i), .limit(len), .cnt(c1), .reached(r1));
  dp_beat_counter #(.W(CNT_WIDTH)) u_o0 (.clk(clk_i), .rst(rst_i), .clr(accept),
    .inc(cnt_en & !add_enable_o & out0_hs_i), .limit(len), .cnt(o0), .reached(q0));
  dp_beat_counter #(.W(CNT_WIDTH)) u_o1 (.clk(clk_i), .rst(rst_i), .clr(accept),
    .inc(cnt_en & out1_hs_i), .limit(len), .cnt(o1), .reached(q1));
`ifdef DP_ADDER_CTRL_ERR_EN
  logic err_set;
  assign err_set = (dp0_hs_i & !gate0_o) | (dp1_hs_i & !gate1_o)
                 | ((out0_hs_i | out1_hs_i) & (state == IDLE || state == SETUP))
                 | (out0_hs_i & q0 & !add_enable_o) | (out1_hs_i & q1)
                 | (add_enable_o & (dp0_hs_i ^ dp1_hs_i));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_o <= 1'b0;
    else err_o <= err_o | err_set;
`else
  assign err_o = 1'b0;
`endif
endmodule
